// File: rtl/frame_stim_pkg.sv
// Shared types and constants for the raster stimulus source:
// FSM state encoding, default descriptor width and the line-generator field layout.
package frame_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_GAPWAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DESC_W_DEFAULT = 69;

    // Line-generator descriptor layout, MSB first:
    // {x0[9:0], y0[9:0], x1[9:0], y1[9:0], 11b, 11b, 3b, 1b, 3b}
    localparam int F_X0_LSB = 59;
    localparam int F_Y0_LSB = 49;
    localparam int F_X1_LSB = 39;
    localparam int F_Y1_LSB = 29;
    localparam int F_A_LSB  = 18;   // 11 bits
    localparam int F_B_LSB  = 7;    // 11 bits
    localparam int F_C_LSB  = 4;    // 3 bits
    localparam int F_D_LSB  = 3;    // 1 bit
    localparam int F_E_LSB  = 0;    // 3 bits

    // Builds a descriptor carrying only endpoints; remaining fields are zero.
    function automatic logic [DESC_W_DEFAULT-1:0] pack_desc(
        input logic [9:0] x0,
        input logic [9:0] y0,
        input logic [9:0] x1,
        input logic [9:0] y1
    );
        logic [DESC_W_DEFAULT-1:0] d;
        d = '0;
        d[F_X0_LSB +: 10] = x0;
        d[F_Y0_LSB +: 10] = y0;
        d[F_X1_LSB +: 10] = x1;
        d[F_Y1_LSB +: 10] = y1;
        return d;
    endfunction

endpackage

// File: rtl/frame_stim_gen_tick.sv
// Free-running frame tick: counts enabled cycles and emits a one-cycle tick
// every PERIOD enabled cycles. en low freezes the count and withholds the tick.
module frame_tick_gen #(
    parameter int PERIOD = 1666667
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles; wrap at PERIOD-1 and register the tick.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == LAST) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_stim_gen.sv
// Raster stimulus source: per frame, replays NUM_OBJ descriptors through a
// FIFO-style read port with optional gaps, flags object boundaries and the
// end of the table, and tracks frames that start before the table drained.
//
// Handshake: fifo_data is valid whenever fifo_empty is low; a read is
// accepted on a rising clk_100mhz edge where fifo_rd_en=1 and fifo_empty=0.
// Reads while empty are ignored. A frame_start in the same cycle wins and
// the read is not consumed.
module frame_stim_gen
    import frame_stim_pkg::*;
#(
    parameter int FRAME_PERIOD  = 1666667,
    parameter int NUM_OBJ       = 4,
    parameter int DESC_W        = 69,
    parameter int GAP           = 0,
    parameter int LINES_PER_OBJ = 1
) (
    input  logic                      clk_100mhz,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OBJ*DESC_W-1:0] obj_table,
    input  logic                      fifo_rd_en,
    output logic [DESC_W-1:0]         fifo_data,
    output logic                      fifo_empty,
    output logic                      frame_start,
    output logic                      obj_change,
    output logic                      end_of_objects,
    output logic [15:0]               frame_count,
    output logic                      overrun,
    output logic [7:0]                overrun_count,
    output logic [1:0]                dbg_state
);

    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OBJ - 1);
    localparam logic [GW-1:0] GAP_START = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state;
    logic [IW-1:0] idx;
    logic [GW-1:0] gap_cnt;
    logic [IW:0]   idx_inc;
    logic          obj_boundary;

    frame_tick_gen #(
        .PERIOD (FRAME_PERIOD)
    ) u_tick (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .en         (en),
        .tick       (frame_start)
    );

    assign dbg_state = state;

    // Next index and whether it lands on an object group boundary.
    always_comb begin
        idx_inc      = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
        obj_boundary = ((int'(idx_inc) % LINES_PER_OBJ) == 0) && (int'(idx_inc) < NUM_OBJ);
    end

    // Present the selected table entry only while a descriptor is valid.
    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (!fifo_empty && idx == IW'(i)) begin
                fifo_data = obj_table[i*DESC_W +: DESC_W];
            end
        end
    end

    // Replay FSM with registered sideband outputs and overrun tracking.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            gap_cnt        <= '0;
            fifo_empty     <= 1'b1;
            obj_change     <= 1'b0;
            end_of_objects <= 1'b0;
            frame_count    <= '0;
            overrun        <= 1'b0;
            overrun_count  <= '0;
        end else begin
            obj_change <= 1'b0;
            if (frame_start) begin
                frame_count <= frame_count + 16'd1;
                if (state == ST_EMIT || state == ST_GAPWAIT) begin
                    overrun <= 1'b1;
                    if (overrun_count != 8'hFF) begin
                        overrun_count <= overrun_count + 8'd1;
                    end
                end
                state          <= ST_EMIT;
                idx            <= '0;
                gap_cnt        <= '0;
                fifo_empty     <= 1'b0;
                end_of_objects <= 1'b0;
            end else begin
                case (state)
                    ST_EMIT: begin
                        if (fifo_rd_en) begin
                            idx        <= idx_inc[IW-1:0];
                            obj_change <= obj_boundary;
                            if (idx == LAST_IDX) begin
                                state          <= ST_DONE;
                                fifo_empty     <= 1'b1;
                                end_of_objects <= 1'b1;
                            end else if (GAP > 0) begin
                                state      <= ST_GAPWAIT;
                                fifo_empty <= 1'b1;
                                gap_cnt    <= GAP_START;
                            end
                        end
                    end
                    ST_GAPWAIT: begin
                        if (gap_cnt == '0) begin
                            state      <= ST_EMIT;
                            fifo_empty <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_stim_gen.sv
// Directed bench for frame_stim_gen: instance A (3 objects, no gap) covers the
// tick, drain, overrun, pause, reset and saturation; instance B (4 objects,
// GAP=2, 2 lines per object) covers gaps and object boundaries.
module tb_frame_stim_gen;
    import frame_stim_pkg::*;

    localparam int FP = 50;
    localparam int W  = 69;
    localparam int NA = 3;
    localparam int NB = 4;

    logic clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    logic            rst_a, en_a, rd_a;
    logic [NA*W-1:0] tbl_a;
    logic [W-1:0]    data_a;
    logic            empty_a, fs_a, oc_a, eoo_a, ovr_a;
    logic [15:0]     fc_a;
    logic [7:0]      ovc_a;
    logic [1:0]      st_a;

    logic            rst_b, en_b, rd_b;
    logic [NB*W-1:0] tbl_b;
    logic [W-1:0]    data_b;
    logic            empty_b, fs_b, oc_b, eoo_b, ovr_b;
    logic [15:0]     fc_b;
    logic [7:0]      ovc_b;
    logic [1:0]      st_b;

    int n_tests = 0;
    int n_fail  = 0;
    int oc_cnt_b = 0;
    int oc_base  = 0;

    frame_stim_gen #(
        .FRAME_PERIOD (FP), .NUM_OBJ (NA), .DESC_W (W), .GAP (0), .LINES_PER_OBJ (1)
    ) dut_a (
        .clk_100mhz (clk_100mhz), .rst (rst_a), .en (en_a), .obj_table (tbl_a),
        .fifo_rd_en (rd_a), .fifo_data (data_a), .fifo_empty (empty_a),
        .frame_start (fs_a), .obj_change (oc_a), .end_of_objects (eoo_a),
        .frame_count (fc_a), .overrun (ovr_a), .overrun_count (ovc_a), .dbg_state (st_a)
    );

    frame_stim_gen #(
        .FRAME_PERIOD (FP), .NUM_OBJ (NB), .DESC_W (W), .GAP (2), .LINES_PER_OBJ (2)
    ) dut_b (
        .clk_100mhz (clk_100mhz), .rst (rst_b), .en (en_b), .obj_table (tbl_b),
        .fifo_rd_en (rd_b), .fifo_data (data_b), .fifo_empty (empty_b),
        .frame_start (fs_b), .obj_change (oc_b), .end_of_objects (eoo_b),
        .frame_count (fc_b), .overrun (ovr_b), .overrun_count (ovc_b), .dbg_state (st_b)
    );

    // Count obj_change pulses of instance B, one sample per cycle.
    always @(negedge clk_100mhz) oc_cnt_b <= oc_cnt_b + int'(oc_b);

    function automatic logic [W-1:0] ea(input int i);
        return pack_desc(10'(17*i + 5), 10'(3*i + 100), 10'(2*i + 7), 10'(i + 1));
    endfunction

    function automatic logic [W-1:0] eb(input int i);
        return pack_desc(10'(40*i + 1), 10'(i + 300), 10'(5*i + 2), 10'(999 - i));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NA; i++) tbl_a[i*W +: W] = ea(i);
        for (int i = 0; i < NB; i++) tbl_b[i*W +: W] = eb(i);
        rst_a = 1'b1; en_a = 1'b1; rd_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b1; rd_b = 1'b1;
        tick(3);

        // Reset values
        check("rst_empty", empty_a, 1);
        check("rst_data", data_a, 0);
        check("rst_fs", fs_a, 0);
        check("rst_oc", oc_a, 0);
        check("rst_eoo", eoo_a, 0);
        check("rst_ovr", ovr_a, 0);
        check("rst_fc", fc_a, 0);
        check("rst_ovc", ovc_a, 0);
        check("rst_state", st_a, ST_IDLE);

        // Frame tick timing
        rst_a = 1'b0;
        tick(49);
        check("t49_fs", fs_a, 0);
        check("t49_empty", empty_a, 1);
        tick(1);
        check("t50_fs", fs_a, 1);
        check("t50_empty", empty_a, 1);
        tick(1);
        check("t51_fs", fs_a, 0);
        check("t51_empty", empty_a, 0);
        check("t51_data", data_a, ea(0));
        check("t51_fc", fc_a, 1);
        check("t51_state", st_a, ST_EMIT);

        // Second tick while undrained: overrun
        tick(49);
        check("t100_fs", fs_a, 1);
        check("t100_ovr", ovr_a, 0);
        tick(1);
        check("t101_ovr", ovr_a, 1);
        check("t101_ovc", ovc_a, 1);
        check("t101_fc", fc_a, 2);
        check("t101_data", data_a, ea(0));

        // Tick coincident with a read: read not consumed, then full drain
        tick(49);
        check("t150_fs", fs_a, 1);
        rd_a = 1'b1;
        tick(1);
        check("t151_data", data_a, ea(0));
        check("t151_empty", empty_a, 0);
        check("t151_ovc", ovc_a, 2);
        check("t151_fc", fc_a, 3);
        tick(1);
        check("t152_data", data_a, ea(1));
        check("t152_oc", oc_a, 1);
        tick(1);
        check("t153_data", data_a, ea(2));
        check("t153_oc", oc_a, 1);
        tick(1);
        check("t154_empty", empty_a, 1);
        check("t154_eoo", eoo_a, 1);
        check("t154_oc", oc_a, 0);
        check("t154_data", data_a, 0);
        check("t154_state", st_a, ST_DONE);

        // Pause: en low for 20 cycles delays the tick by 20
        tick(26);
        check("t180_eoo", eoo_a, 1);
        check("t180_empty", empty_a, 1);
        en_a = 1'b0;
        tick(20);
        check("t200_fs", fs_a, 0);
        en_a = 1'b1;
        tick(19);
        check("t219_fs", fs_a, 0);
        tick(1);
        check("t220_fs", fs_a, 1);
        check("t220_eoo", eoo_a, 1);
        tick(1);
        check("t221_eoo", eoo_a, 0);
        check("t221_empty", empty_a, 0);
        check("t221_fc", fc_a, 4);
        check("t221_ovc", ovc_a, 2);
        check("t221_data", data_a, ea(0));

        // Reset mid-EMIT
        rst_a = 1'b1; rd_a = 1'b0;
        tick(1);
        check("mrst_empty", empty_a, 1);
        check("mrst_data", data_a, 0);
        check("mrst_fs", fs_a, 0);
        check("mrst_oc", oc_a, 0);
        check("mrst_eoo", eoo_a, 0);
        check("mrst_ovr", ovr_a, 0);
        check("mrst_fc", fc_a, 0);
        check("mrst_ovc", ovc_a, 0);
        check("mrst_state", st_a, ST_IDLE);
        rst_a = 1'b0;
        tick(49);
        check("r49_fs", fs_a, 0);
        tick(1);
        check("r50_fs", fs_a, 1);
        tick(1);
        check("r51_empty", empty_a, 0);
        check("r51_ovr", ovr_a, 0);
        check("r51_fc", fc_a, 1);

        // Repeated overruns: count saturates at 255
        tick(500);
        check("sat10_ovc", ovc_a, 10);
        tick(12200);
        check("sat254_ovc", ovc_a, 254);
        tick(50);
        check("sat255_ovc", ovc_a, 255);
        tick(2250);
        check("sat300_ovc", ovc_a, 255);
        check("sat300_ovr", ovr_a, 1);
        check("sat300_fc", fc_a, 301);
        rst_a = 1'b1;

        // Instance B: GAP=2, two lines per object, reads always requested
        rst_b = 1'b0;
        tick(50);
        check("b50_fs", fs_b, 1);
        check("b50_empty", empty_b, 1);
        oc_base = oc_cnt_b;
        tick(1);
        check("b51_data", data_b, eb(0));
        check("b51_empty", empty_b, 0);
        tick(1);
        check("b52_empty", empty_b, 1);
        check("b52_oc", oc_b, 0);
        tick(1);
        check("b53_empty", empty_b, 1);
        check("b53_state", st_b, ST_GAPWAIT);
        tick(1);
        check("b54_data", data_b, eb(1));
        check("b54_empty", empty_b, 0);
        tick(1);
        check("b55_oc", oc_b, 1);
        check("b55_empty", empty_b, 1);
        tick(2);
        check("b57_data", data_b, eb(2));
        tick(1);
        check("b58_oc", oc_b, 0);
        tick(2);
        check("b60_data", data_b, eb(3));
        tick(1);
        check("b61_eoo", eoo_b, 1);
        check("b61_empty", empty_b, 1);
        check("b61_oc", oc_b, 0);
        check("b61_state", st_b, ST_DONE);
        tick(5);
        check("b_oc_total", 32'(oc_cnt_b - oc_base), 1);
        check("b66_eoo", eoo_b, 1);
        check("b66_ovr", ovr_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
